y_alu: RTL and testbench
========================

Name: y_alu

Overview:
- 32-bit ALU with a registered result and a zero flag.
- Supports AND, OR, ADD, SUB and signed set-less-than (SLT), selected by a 3-bit opcode.
- Sits in the CPU datapath execute stage. It is the unit the datapath uses for address/arithmetic results and for branch-equality detection via the zero flag.
- Single clock domain; asynchronous active-low reset.

Parameters:
- none. Width is fixed at 32 bits; opcode at 3 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  32  operand A, two's-complement signed for SLT.
- b  input  32  operand B, two's-complement signed for SLT.
- op  input  3  operation select.
- z  output  32  registered result.
- ex  output  1  registered zero flag: 1 when the registered z is all zeros.

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0, z=32'h0 and ex=1, independent of clk. The first capture occurs on the first rising clk edge with rst_n=1.
- Latency is 1 cycle. On each rising clk edge with rst_n=1, the block computes f(a, b, op) combinationally from the current inputs and loads it into z. There is no enable and no handshake: a new result every cycle.
- Opcode map:
  - 000: z = a & b (bitwise).
  - 001: z = a | b (bitwise).
  - 010: z = a + b, modulo 2^32. Carry-out discarded; no overflow output.
  - 110: z = a - b, computed as a + ~b + 1, modulo 2^32. Borrow discarded.
  - 111: SLT, z = {31'b0, lt}. lt = 1 iff a < b as signed 32-bit.
  - 011, 100, 101 (unused): z = 32'h0, so ex = 1.
- SLT implementation: compute d = a - b with the shared adder. lt = d[31] XOR ovf, where ovf = (a[31] != b[31]) && (d[31] != a[31]). This must be correct at the extremes: a=32'h80000000 vs b=32'h7FFFFFFF gives lt=1; the reverse gives lt=0.
- Adder structure: a single 32-bit adder is shared by ADD, SUB and SLT. op[2] drives both the B-inversion and the carry-in. Result selection uses op[1:0] between logic/arith/SLT paths, with the unused-op override to zero.
- ex is registered together with z and is always equal to (z == 0). The two are never out of step by a cycle.
- Equal operands:
  - SUB gives z=0, ex=1.
  - SLT gives z=0, ex=1.
  - AND/OR give z=a.
- Reset asserted mid-operation: outputs go immediately to z=0, ex=1. Any in-flight result is discarded. Reset release must be synchronised by the system; the block itself adds no synchroniser.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect on the outputs.

Test Plan:
- Reset: hold rst_n=0 with a=5, b=7, op=010 and toggle clk -> z=0, ex=1 throughout. Release reset; after one edge, z=12, ex=0.
- Logic ops: a=32'hF0F0_1234, b=32'h0FF0_FF00. op=000 -> z=32'h00F0_1200, ex=0 one cycle later. op=001 -> z=32'hFFF0_FF34.
- Add/sub wrap: a=32'hFFFF_FFFF, b=1. op=010 -> z=0, ex=1. op=110 -> z=32'hFFFF_FFFE. Also a=b=32'h1234_5678 with op=110 -> z=0, ex=1.
- Signed SLT:
  - a=-3, b=2, op=111 -> z=1, ex=0.
  - a=2, b=-3 -> z=0, ex=1.
  - a=32'h8000_0000, b=32'h7FFF_FFFF -> z=1.
  - a=b -> z=0.
- Unused ops: op=011, 100, 101 with a=b=32'hFFFF_FFFF -> z=0, ex=1.
- Back-to-back and random: change op and operands every cycle; each z/ex matches the reference model of the previous cycle's inputs. Run at least 1000 random vectors, with 50% of them forcing b=a.

Source files
------------

// File: rtl/y_alu.sv
// y_alu: 32-bit ALU (AND/OR/ADD/SUB/SLT) with registered result and zero flag.
// One shared adder serves ADD, SUB and SLT; op[2] selects subtraction.
module y_alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   output logic [31:0] z,
   output logic        ex
);
   logic [31:0] b_x, sum, z_d, z_q;
   logic        ex_q, ovf, lt, valid;
   assign b_x   = op[2] ? ~b : b;
   assign sum   = a + b_x + {31'b0, op[2]};
   // signed overflow of a - b flips the sign bit's meaning
   assign ovf   = (a[31] != b[31]) && (sum[31] != a[31]);
   assign lt    = sum[31] ^ ovf;
   assign valid = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                  (op == 3'b110) || (op == 3'b111);
   always_comb begin
      z_d = !valid              ? 32'h0 :
            (op[1:0] == 2'b00)  ? (a & b) :
            (op[1:0] == 2'b01)  ? (a | b) :
            (op[1:0] == 2'b10)  ? sum :
                                  {31'b0, lt};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_q  <= 32'h0;
         ex_q <= 1'b1;
      end else begin
         z_q  <= z_d;
         ex_q <= (z_d == 32'h0);
      end
   end
   assign z  = z_q;
   assign ex = ex_q;
endmodule

// File: tb/tb_y_alu.sv
// tb_y_alu: scoreboard bench for y_alu; expected results queued at drive time,
// popped and compared one cycle later.
module tb_y_alu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [2:0]  op = '0;
   logic [31:0] z;
   logic        ex;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb[$];

   y_alu dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .z(z), .ex(ex));

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic [2:0] mop);
      case (mop)
         3'b000:  return ma & mb;
         3'b001:  return ma | mb;
         3'b010:  return ma + mb;
         3'b110:  return ma - mb;
         3'b111:  return {31'b0, ($signed(ma) < $signed(mb))};
         default: return 32'h0;
      endcase
   endfunction

   task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic [2:0] dop,
                        input logic [31:0] ez);
      a = da;
      b = db;
      op = dop;
      sb.push_back(ez);
   endtask

   task automatic test_reset();
      logic [31:0] ez;
      rst_n = 1'b0;
      a = 32'd5;
      b = 32'd7;
      op = 3'b010;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (z !== 32'h0) begin failures++; $display("FAIL reset_z[%0d] got=%h exp=0", i, z); end
         checks++;
         if (ex !== 1'b1) begin failures++; $display("FAIL reset_ex[%0d] got=%b exp=1", i, ex); end
      end
      rst_n = 1'b1;
      drive(32'd5, 32'd7, 3'b010, 32'd12);
      @(posedge clk); #1;
      ez = sb.pop_front();
      checks++;
      if (z !== ez) begin failures++; $display("FAIL release_z got=%h exp=%h", z, ez); end
      checks++;
      if (ex !== 1'b0) begin failures++; $display("FAIL release_ex got=%b exp=0", ex); end
   endtask

   task automatic run_table(input string name, input logic [31:0] ta[], input logic [31:0] tbv[],
                            input logic [2:0] top[], input logic [31:0] tz[]);
      logic [31:0] ez;
      for (int i = 0; i < ta.size(); i++) begin
         drive(ta[i], tbv[i], top[i], tz[i]);
         @(posedge clk); #1;
         ez = sb.pop_front();
         checks++;
         if (z !== ez) begin failures++; $display("FAIL %s_z[%0d] got=%h exp=%h", name, i, z, ez); end
         checks++;
         if (ex !== (ez == 32'h0)) begin
            failures++; $display("FAIL %s_ex[%0d] got=%b exp=%b", name, i, ex, ez == 32'h0);
         end
      end
   endtask

   task automatic test_logic();
      run_table("logic",
         '{32'hF0F0_1234, 32'hF0F0_1234, 32'hA5A5_5A5A, 32'hA5A5_5A5A},
         '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'hA5A5_5A5A, 32'hA5A5_5A5A},
         '{3'b000, 3'b001, 3'b000, 3'b001},
         '{32'h00F0_1200, 32'hFFF0_FF34, 32'hA5A5_5A5A, 32'hA5A5_5A5A});
   endtask

   task automatic test_addsub();
      run_table("addsub",
         '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0},
         '{32'd1,         32'd1,         32'h1234_5678, 32'd1},
         '{3'b010, 3'b110, 3'b110, 3'b110},
         '{32'h0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF});
   endtask

   task automatic test_slt();
      run_table("slt",
         '{32'hFFFF_FFFD, 32'd2,         32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF},
         '{32'd2,         32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'd0},
         '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111},
         '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1});
   endtask

   task automatic test_unused();
      run_table("unused",
         '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{3'b011, 3'b100, 3'b101},
         '{32'h0, 32'h0, 32'h0});
   endtask

   task automatic test_async_reset();
      logic [31:0] ez;
      drive(32'h0000_0F00, 32'h0000_00F0, 3'b001, 32'h0000_0FF0);
      @(posedge clk); #1;
      ez = sb.pop_front();
      checks++;
      if (z !== ez) begin failures++; $display("FAIL async_pre_z got=%h exp=%h", z, ez); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (z !== 32'h0) begin failures++; $display("FAIL async_z got=%h exp=0", z); end
      checks++;
      if (ex !== 1'b1) begin failures++; $display("FAIL async_ex got=%b exp=1", ex); end
      #1 rst_n = 1'b1;
      drive(32'd40, 32'd2, 3'b010, 32'd42);
      @(posedge clk); #1;
      ez = sb.pop_front();
      checks++;
      if (z !== ez) begin failures++; $display("FAIL async_post_z got=%h exp=%h", z, ez); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ra, rb, ez;
      logic [2:0]  rop;
      for (int i = 0; i < 1000; i++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 1) == 1) ? ra : $urandom;
         rop = 3'($urandom_range(0, 7));
         drive(ra, rb, rop, model(ra, rb, rop));
         @(posedge clk); #1;
         ez = sb.pop_front();
         checks++;
         if (z !== ez) begin
            failures++;
            $display("FAIL rand_z[%0d] a=%h b=%h op=%b got=%h exp=%h", i, ra, rb, rop, z, ez);
         end
         checks++;
         if (ex !== (ez == 32'h0)) begin
            failures++; $display("FAIL rand_ex[%0d] got=%b exp=%b", i, ex, ez == 32'h0);
         end
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_logic();
      test_addsub();
      test_slt();
      test_unused();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
